time_keeper: RTL and testbench

//   Free-running calendar clock downstream of the setting-mode FSM. Loads month/day/hour/min/sec

---
 rtl/time_keeper_pkg.sv | 51 +++++
 rtl/time_keeper_if.sv | 30 +++
 rtl/time_keeper_days_in_month.sv | 19 +
 rtl/time_keeper.sv | 115 +++++++++++
 tb/tb_time_keeper.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/time_keeper_pkg.sv
// Shared calendar limits, time/tick record types and load-clamping helpers
// for the clock setter, time keeper and alarm stages.
package time_keeper_pkg;

  localparam logic [5:0] MAX_SEC   = 6'd59;
  localparam logic [5:0] MAX_MIN   = 6'd59;
  localparam logic [4:0] MAX_HOUR  = 5'd23;
  localparam logic [3:0] MAX_MONTH = 4'd12;
  localparam logic [4:0] DIM_FEB   = 5'd28;
  localparam logic [4:0] DIM_SHORT = 5'd30;
  localparam logic [4:0] DIM_LONG  = 5'd31;

  typedef struct packed {
    logic [3:0] month;
    logic [4:0] day;
    logic [4:0] hour;
    logic [5:0] min;
    logic [5:0] sec;
  } cal_time_t;

  typedef struct packed {
    logic sec;
    logic min;
    logic day;
  } tick_t;

  localparam cal_time_t RESET_TIME = '{month: 4'd1, day: 5'd1, hour: 5'd0,
                                       min: 6'd0, sec: 6'd0};

  function automatic logic [3:0] clamp_month(input logic [3:0] m);
    if (m == 4'd0)       return 4'd1;
    if (m > MAX_MONTH)   return MAX_MONTH;
    return m;
  endfunction

  // The day limit must come from the already-clamped month.
  function automatic logic [4:0] clamp_day(input logic [4:0] d, input logic [4:0] dim);
    if (d == 5'd0) return 5'd1;
    if (d > dim)   return dim;
    return d;
  endfunction

  function automatic logic [4:0] clamp_hour(input logic [4:0] h);
    return (h > MAX_HOUR) ? MAX_HOUR : h;
  endfunction

  function automatic logic [5:0] clamp_min_sec(input logic [5:0] v, input logic [5:0] max_v);
    return (v > max_v) ? max_v : v;
  endfunction

endpackage

// File: rtl/time_keeper_if.sv
// Time-keeper bus: load/hold request from the setter, current time and tick
// strobes towards the display and alarm stages.
interface time_keeper_if;
  logic       load;
  logic       hold;
  logic [5:0] ld_sec;
  logic [5:0] ld_min;
  logic [4:0] ld_hour;
  logic [4:0] ld_day;
  logic [3:0] ld_month;

  logic [5:0] sec;
  logic [5:0] min;
  logic [4:0] hour;
  logic [4:0] day;
  logic [3:0] month;
  logic       sec_tick;
  logic       min_tick;
  logic       day_tick;

  modport master (
    output load, hold, ld_sec, ld_min, ld_hour, ld_day, ld_month,
    input  sec, min, hour, day, month, sec_tick, min_tick, day_tick
  );

  modport slave (
    input  load, hold, ld_sec, ld_min, ld_hour, ld_day, ld_month,
    output sec, min, hour, day, month, sec_tick, min_tick, day_tick
  );
endinterface

// File: rtl/time_keeper_days_in_month.sv
// Days in a month of the fixed 365-day calendar; out-of-range months map to 28.
module time_keeper_days_in_month
  import time_keeper_pkg::*;
(
  input  logic [3:0] month_i,
  output logic [4:0] dim_o
);

  always_comb begin
    // NOTE: a default is assigned before the case so every path drives dim_o and no latch is inferred.
    dim_o = DIM_FEB;
    case (month_i)
      4'd1, 4'd3, 4'd5, 4'd7, 4'd8, 4'd10, 4'd12: dim_o = DIM_LONG;
      4'd4, 4'd6, 4'd9, 4'd11:                    dim_o = DIM_SHORT;
      default:                                    dim_o = DIM_FEB;
    endcase
  end

endmodule

// File: rtl/time_keeper.sv
// Free-running calendar clock: loads a clamped time from the setter, then
// advances once per second off a clk prescaler, with registered tick strobes.
module time_keeper
  import time_keeper_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 100_000_000
) (
  input  logic          clk,
  input  logic          rst,
  time_keeper_if.slave  bus
);

  localparam int unsigned     PW         = $clog2(CLK_FREQ);
  localparam logic [PW-1:0]   PRESC_LAST = PW'(CLK_FREQ - 1);

  cal_time_t     time_q, time_d;
  cal_time_t     ld_time, adv_time;
  tick_t         tick_q, tick_d, adv_tick;
  logic [PW-1:0] presc_q, presc_d;
  logic [3:0]    ld_month_c;
  logic [4:0]    ld_dim, run_dim;
  logic          presc_tick;

  assign ld_month_c = clamp_month(bus.ld_month);
  assign presc_tick = (presc_q == PRESC_LAST);

  time_keeper_days_in_month u_dim_load (
    .month_i (ld_month_c),
    .dim_o   (ld_dim)
  );

  time_keeper_days_in_month u_dim_run (
    .month_i (time_q.month),
    .dim_o   (run_dim)
  );

  always_comb begin
    ld_time.month = ld_month_c;
    ld_time.day   = clamp_day(bus.ld_day, ld_dim);
    ld_time.hour  = clamp_hour(bus.ld_hour);
    ld_time.min   = clamp_min_sec(bus.ld_min, MAX_MIN);
    ld_time.sec   = clamp_min_sec(bus.ld_sec, MAX_SEC);
  end

  // One-second advance with the full carry chain resolved in a single edge.
  always_comb begin
    adv_time     = time_q;
    adv_tick     = '0;
    adv_tick.sec = 1'b1;
    if (time_q.sec != MAX_SEC) begin
      adv_time.sec = time_q.sec + 6'd1;
    end else begin
      adv_time.sec = 6'd0;
      adv_tick.min = 1'b1;
      if (time_q.min != MAX_MIN) begin
        adv_time.min = time_q.min + 6'd1;
      end else begin
        adv_time.min = 6'd0;
        if (time_q.hour != MAX_HOUR) begin
          adv_time.hour = time_q.hour + 5'd1;
        end else begin
          adv_time.hour = 5'd0;
          adv_tick.day  = 1'b1;
          if (time_q.day != run_dim) begin
            adv_time.day = time_q.day + 5'd1;
          end else begin
            adv_time.day   = 5'd1;
            adv_time.month = (time_q.month == MAX_MONTH) ? 4'd1 : time_q.month + 4'd1;
          end
        end
      end
    end
  end

  always_comb begin
    time_d  = time_q;
    presc_d = presc_q;
    tick_d  = '0;
    if (bus.load) begin
      time_d  = ld_time;
      presc_d = '0;
    end else if (!bus.hold) begin
      if (presc_tick) begin
        presc_d = '0;
        time_d  = adv_time;
        tick_d  = adv_tick;
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples the pre-edge values of the others.
    if (rst) begin
      time_q  <= RESET_TIME;
      presc_q <= '0;
      tick_q  <= '0;
    end else begin
      time_q  <= time_d;
      presc_q <= presc_d;
      tick_q  <= tick_d;
    end
  end

  assign bus.sec      = time_q.sec;
  assign bus.min      = time_q.min;
  assign bus.hour     = time_q.hour;
  assign bus.day      = time_q.day;
  assign bus.month    = time_q.month;
  assign bus.sec_tick = tick_q.sec;
  assign bus.min_tick = tick_q.min;
  assign bus.day_tick = tick_q.day;

endmodule

// File: tb/tb_time_keeper.sv
// Bench for time_keeper: seconds-of-year reference model checked every cycle,
// plus directed loads/holds/resets with literal expectations.
module tb_time_keeper;

  localparam int CF     = 4;
  localparam int DAY_S  = 86400;
  localparam int YEAR_S = 365 * DAY_S;

  logic clk = 1'b0;
  logic rst = 1'b1;

  time_keeper_if bus();

  time_keeper #(.CLK_FREQ(CF)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  int cum_days[12] = '{0, 31, 59, 90, 120, 151, 181, 212, 243, 273, 304, 334};
  int dim_tab[12]  = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};

  // Reference state: seconds since Jan 1 00:00:00 and clk cycles into the current second.
  int m_t = 0;
  int m_p = 0;
  bit m_st = 1'b0, m_mt = 1'b0, m_dt = 1'b0;
  bit m_valid = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int to_secs(int mo, int d, int h, int mi, int s);
    return (cum_days[mo-1] + d - 1) * DAY_S + h * 3600 + mi * 60 + s;
  endfunction

  task automatic from_secs(input int t, output int mo, output int d, output int h,
                           output int mi, output int s);
    int doy;
    doy = t / DAY_S;
    mo  = 1;
    d   = 1;
    for (int i = 11; i >= 0; i--) begin
      if (doy >= cum_days[i]) begin
        mo = i + 1;
        d  = doy - cum_days[i] + 1;
        break;
      end
    end
    h  = (t % DAY_S) / 3600;
    mi = (t % 3600) / 60;
    s  = t % 60;
  endtask

  task automatic model_step();
    int mo, d, h, mi, s;
    if (rst) begin
      m_t = 0; m_p = 0; m_st = 0; m_mt = 0; m_dt = 0; m_valid = 1'b1;
    end else if (bus.load) begin
      mo = int'(bus.ld_month);
      if (mo < 1)  mo = 1;
      if (mo > 12) mo = 12;
      d = int'(bus.ld_day);
      if (d < 1) d = 1;
      if (d > dim_tab[mo-1]) d = dim_tab[mo-1];
      h  = (int'(bus.ld_hour) > 23) ? 23 : int'(bus.ld_hour);
      mi = (int'(bus.ld_min)  > 59) ? 59 : int'(bus.ld_min);
      s  = (int'(bus.ld_sec)  > 59) ? 59 : int'(bus.ld_sec);
      m_t = to_secs(mo, d, h, mi, s);
      m_p = 0; m_st = 0; m_mt = 0; m_dt = 0;
    end else if (bus.hold) begin
      m_st = 0; m_mt = 0; m_dt = 0;
    end else if (m_p == CF - 1) begin
      m_p  = 0;
      m_t  = (m_t + 1) % YEAR_S;
      m_st = 1'b1;
      m_mt = (m_t % 60) == 0;
      m_dt = (m_t % DAY_S) == 0;
    end else begin
      m_p++;
      m_st = 0; m_mt = 0; m_dt = 0;
    end
  endtask

  always @(posedge clk) begin
    int mo, d, h, mi, s;
    model_step();
    #1;
    if (m_valid) begin
      from_secs(m_t, mo, d, h, mi, s);
      check("model.sec",      bus.sec,      s);
      check("model.min",      bus.min,      mi);
      check("model.hour",     bus.hour,     h);
      check("model.day",      bus.day,      d);
      check("model.month",    bus.month,    mo);
      check("model.sec_tick", bus.sec_tick, m_st);
      check("model.min_tick", bus.min_tick, m_mt);
      check("model.day_tick", bus.day_tick, m_dt);
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic set_ld(input int mo, input int d, input int h, input int mi, input int s);
    bus.ld_month = 4'(mo);
    bus.ld_day   = 5'(d);
    bus.ld_hour  = 5'(h);
    bus.ld_min   = 6'(mi);
    bus.ld_sec   = 6'(s);
  endtask

  task automatic do_load(input int mo, input int d, input int h, input int mi, input int s);
    set_ld(mo, d, h, mi, s);
    bus.load = 1'b1;
    step(1);
    bus.load = 1'b0;
  endtask

  task automatic expect_now(input string tag, input int mo, input int d, input int h,
                            input int mi, input int s, input int st, input int mt, input int dt);
    check({tag, ".month"},    bus.month,    mo);
    check({tag, ".day"},      bus.day,      d);
    check({tag, ".hour"},     bus.hour,     h);
    check({tag, ".min"},      bus.min,      mi);
    check({tag, ".sec"},      bus.sec,      s);
    check({tag, ".sec_tick"}, bus.sec_tick, st);
    check({tag, ".min_tick"}, bus.min_tick, mt);
    check({tag, ".day_tick"}, bus.day_tick, dt);
  endtask

  initial begin
    bus.load = 1'b0;
    bus.hold = 1'b0;
    set_ld(0, 0, 0, 0, 0);
    rst = 1'b1;
    step(1);
    expect_now("reset", 1, 1, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;

    step(12);
    expect_now("idle12", 1, 1, 0, 0, 3, 1, 0, 0);
    step(1);
    expect_now("idle13", 1, 1, 0, 0, 3, 0, 0, 0);

    do_load(2, 28, 23, 59, 59);
    expect_now("ld_feb28", 2, 28, 23, 59, 59, 0, 0, 0);
    step(4);
    expect_now("feb_roll", 3, 1, 0, 0, 0, 1, 1, 1);

    do_load(12, 31, 23, 59, 59);
    step(4);
    expect_now("year_roll", 1, 1, 0, 0, 0, 1, 1, 1);

    do_load(0, 31, 30, 63, 60);
    expect_now("clamp_hi", 1, 31, 23, 59, 59, 0, 0, 0);
    do_load(15, 0, 0, 0, 0);
    expect_now("clamp_mon", 12, 1, 0, 0, 0, 0, 0, 0);
    do_load(4, 31, 10, 20, 30);
    expect_now("clamp_apr", 4, 30, 10, 20, 30, 0, 0, 0);

    // Two counts into the second, then freeze for 20 cycles.
    step(2);
    bus.hold = 1'b1;
    step(20);
    expect_now("hold", 4, 30, 10, 20, 30, 0, 0, 0);
    bus.hold = 1'b0;
    step(1);
    expect_now("hold_rel1", 4, 30, 10, 20, 30, 0, 0, 0);
    step(1);
    expect_now("hold_rel2", 4, 30, 10, 20, 31, 1, 0, 0);

    // Reset wins over load on an edge where the prescaler is terminal.
    step(3);
    rst = 1'b1;
    bus.load = 1'b1;
    set_ld(9, 9, 9, 9, 9);
    step(1);
    expect_now("rst_over_ld", 1, 1, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    bus.load = 1'b0;

    // Load on a terminal-prescaler edge suppresses the tick and restarts the second.
    step(3);
    do_load(6, 15, 12, 0, 0);
    expect_now("ld_on_tick", 6, 15, 12, 0, 0, 0, 0, 0);
    step(3);
    expect_now("ld_on_tick3", 6, 15, 12, 0, 0, 0, 0, 0);
    step(1);
    expect_now("ld_on_tick4", 6, 15, 12, 0, 1, 1, 0, 0);

    do_load(4, 30, 23, 59, 59);
    step(4);
    expect_now("apr_roll", 5, 1, 0, 0, 0, 1, 1, 1);
    do_load(6, 30, 22, 59, 59);
    step(4);
    expect_now("hour_roll", 6, 30, 23, 0, 0, 1, 1, 0);

    // Free run across a minute wrap and a month end, with a short hold in the middle.
    do_load(1, 31, 23, 59, 30);
    step(CF * 20);
    bus.hold = 1'b1;
    step(7);
    bus.hold = 1'b0;
    step(CF * 30);
    do_load(11, 30, 23, 59, 58);
    step(CF * 5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
